lva_frames: RTL

- Parametrised successor to the single-window local variable array.
- Holds the local variable slots for a stack of method frames in one block RAM.
- Supports frame push/pop on invoke/return, plus frame-relative read/write.
- Sits between the control unit and the LVA memory; uses the same trigger/done handshake as the other control-side memories.

---
 rtl/lva_frames.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lva_frames.sv
// lva_frames: frame-stacked local variable array.
// One block RAM holds the local slots of every active method frame. A small
// metadata stack keeps {frame_base, cur_size} of each suspended caller.
// Operations use a trigger/done handshake: one op is in flight at a time and
// takes three cycles from trigger to the done cycle.
// Build option: define LVA_BOUNDS_CHECK_EN to reject slot indices outside the
// current frame and pushes that would run past the end of the RAM.
//
// state | meaning
// IDLE  | waiting for trigger; the done/error pulse is visible here
// READ  | RAM read of frame_base+index in progress
// WRITE | RAM write enable asserted for this single cycle
// PUSH  | caller frame saved, new frame installed
// POP   | caller frame restored from metadata stack
// OUT   | result settles; done/error are registered on the way to IDLE
module lva_frames #(
  parameter int DATA       = 32,
  parameter int LVA_SIZE   = 1024,
  parameter int MAX_FRAMES = 16,
  parameter int ADDR       = $clog2(LVA_SIZE),
  parameter int FDEPTH     = $clog2(MAX_FRAMES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [1:0]        op,
  input  logic [ADDR-1:0]   index,
  input  logic [ADDR-1:0]   frame_size,
  input  logic [DATA-1:0]   writevalue,
  output logic [DATA-1:0]   readvalue,
  output logic              done,
  output logic              busy,
  output logic              error,
  output logic [ADDR-1:0]   frame_base,
  output logic [FDEPTH-1:0] depth
);

  localparam int SIDX = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [FDEPTH-1:0] FULL = FDEPTH'(MAX_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_PUSH, S_POP, S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [ADDR-1:0]   index_q, fsize_q;
  logic [DATA-1:0]   wval_q;
  logic [DATA-1:0]   rd_q;
  logic [DATA-1:0]   readvalue_q;
  logic              done_q, error_q, err_q, err_d;
  logic [ADDR-1:0]   base_q, size_q;
  logic [FDEPTH-1:0] depth_q;
  logic [ADDR-1:0]   addr;

  logic [DATA-1:0]   mem [LVA_SIZE];
  logic [ADDR-1:0]   stk_base [MAX_FRAMES];
  logic [ADDR-1:0]   stk_size [MAX_FRAMES];

  // Physical address wraps modulo 2^ADDR; no carry-out is kept.
  assign addr = base_q + index_q;

`ifdef LVA_BOUNDS_CHECK_EN
  // Two extra bits so base+size+new size cannot overflow before the compare.
  localparam logic [ADDR+1:0] LIMIT = (ADDR+2)'(LVA_SIZE);
  logic [ADDR+1:0] push_sum;
  assign push_sum = {2'b00, base_q} + {2'b00, size_q} + {2'b00, fsize_q};
`endif

  // Next state and per-op rejection decision.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          case (op)
            2'b00:   state_d = S_READ;
            2'b01:   state_d = S_WRITE;
            2'b10:   state_d = S_PUSH;
            default: state_d = S_POP;
          endcase
        end
      end
      S_READ, S_WRITE: begin
        state_d = S_OUT;
`ifdef LVA_BOUNDS_CHECK_EN
        err_d = (index_q >= size_q);
`endif
      end
      S_PUSH: begin
        state_d = S_OUT;
`ifdef LVA_BOUNDS_CHECK_EN
        err_d = (depth_q == FULL) || (push_sum > LIMIT);
`else
        err_d = (depth_q == FULL);
`endif
      end
      S_POP: begin
        state_d = S_OUT;
        err_d   = (depth_q == '0);
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, frame registers and the registered done/error/readvalue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      readvalue_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      size_q      <= '0;
      depth_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_OUT);
      error_q <= (state_q == S_OUT) && err_q;
      if (state_q inside {S_READ, S_WRITE, S_PUSH, S_POP}) err_q <= err_d;
      if (state_q == S_PUSH && !err_d) begin
        base_q  <= base_q + size_q;
        size_q  <= fsize_q;
        depth_q <= depth_q + FDEPTH'(1);
      end
      if (state_q == S_POP && !err_d) begin
        base_q  <= stk_base[SIDX'(depth_q - FDEPTH'(1))];
        size_q  <= stk_size[SIDX'(depth_q - FDEPTH'(1))];
        depth_q <= depth_q - FDEPTH'(1);
      end
      if (state_q == S_OUT && op_q == 2'b00 && !err_q) readvalue_q <= rd_q;
    end
  end

  // Operands are latched at trigger so the requester may change them afterwards.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && trigger) begin
      op_q    <= op;
      index_q <= index;
      fsize_q <= frame_size;
      wval_q  <= writevalue;
    end
  end

  // Caller frame is saved on the metadata stack when a push is accepted.
  always_ff @(posedge clk) begin
    if (state_q == S_PUSH && !err_d) begin
      stk_base[SIDX'(depth_q)] <= base_q;
      stk_size[SIDX'(depth_q)] <= size_q;
    end
  end

  // Slot RAM: single-cycle write enable, synchronous one-cycle read.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE && !err_d) mem[addr] <= wval_q;
    rd_q <= mem[addr];
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign readvalue  = readvalue_q;
  assign frame_base = base_q;
  assign depth      = depth_q;

endmodule
